// File: rtl/id_decode_pkg.sv
// Opcode map, field layout and per-opcode register-use helpers for the decode stage.
package id_decode_pkg;

  localparam logic [4:0] OP_NOP     = 5'd0;
  localparam logic [4:0] OP_LD      = 5'd1;
  localparam logic [4:0] OP_ST      = 5'd2;
  localparam logic [4:0] OP_JMP     = 5'd3;
  localparam logic [4:0] OP_BEQ     = 5'd4;
  localparam logic [4:0] OP_ALU_MIN = 5'd5;

  typedef struct packed {
    logic [4:0]  op;
    logic [8:0]  rd;
    logic [8:0]  rs;
    logic [8:0]  rt;
    logic [26:0] dir;
  } instr_fields_t;

  typedef struct packed {
    logic       valid;
    logic [8:0] rd;
    logic       is_ld;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_READY,
    ST_STALL
  } state_t;

  function automatic logic writes_rd(logic [4:0] op);
    return (op == OP_LD) || (op >= OP_ALU_MIN);
  endfunction

  function automatic logic reads_rs(logic [4:0] op);
    return (op != OP_NOP) && (op != OP_JMP);
  endfunction

  function automatic logic reads_rt(logic [4:0] op);
    return (op != OP_NOP) && (op != OP_JMP);
  endfunction

  function automatic logic is_load(logic [4:0] op);
    return op == OP_LD;
  endfunction

  // Dir deliberately overlaps the rd/rs/rt bits.
  function automatic instr_fields_t split(logic [31:0] instr);
    instr_fields_t f;
    f.op  = instr[31:27];
    f.rd  = instr[26:18];
    f.rs  = instr[17:9];
    f.rt  = instr[8:0];
    f.dir = instr[26:0];
    return f;
  endfunction

endpackage

// File: rtl/id_decode_if.sv
// Instruction handshake plus ID/EX-register drive bundle for id_decode_stage.
interface id_decode_if #(
  parameter int unsigned CNT_W = 16
);
  logic             instr_valid;
  logic [31:0]      instr;
  logic             instr_ready;
  logic             flush;
  logic [4:0]       OpCode;
  logic [8:0]       Rd;
  logic [8:0]       Rs;
  logic [8:0]       Rt;
  logic [26:0]      Dir;
  logic             out_valid;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output instr_valid, instr, flush,
    input  instr_ready, OpCode, Rd, Rs, Rt, Dir, out_valid, stall_cnt
  );

  modport slave (
    input  instr_valid, instr, flush,
    output instr_ready, OpCode, Rd, Rs, Rt, Dir, out_valid, stall_cnt
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Shift register of recently issued writers; flags a RAW hazard for the held instruction.
// Build option ID_DECODE_FWD_EN: only loads are tracked, against LOAD_DIST.
module id_hazard_scoreboard
  import id_decode_pkg::*;
#(
  parameter int unsigned NOFWD_DIST = 3,
  parameter int unsigned LOAD_DIST  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  sb_entry_t  push,
  input  logic [8:0] rs,
  input  logic [8:0] rt,
  input  logic       use_rs,
  input  logic       use_rt,
  output logic       hazard
);
`ifdef ID_DECODE_FWD_EN
  localparam bit LOADS_ONLY = 1'b1;
`else
  localparam bit LOADS_ONLY = 1'b0;
`endif
  localparam int unsigned DIST  = LOADS_ONLY ? LOAD_DIST : NOFWD_DIST;
  localparam int unsigned DEPTH = NOFWD_DIST - 1;

  sb_entry_t sb [DEPTH];

  // Entry k holds the slot issued k+1 edges ago; bubbles shift in as empty entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) sb[k] <= '0;
    end else begin
      sb[0] <= push;
      for (int unsigned k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (sb[k].valid && (!LOADS_ONLY || sb[k].is_ld) && (k + 1 < DIST) &&
          ((use_rs && rs != '0 && sb[k].rd == rs) ||
           (use_rt && rt != '0 && sb[k].rd == rt)))
        hazard = 1'b1;
    end
  end

endmodule

// File: rtl/id_decode_stage.sv
// Decode stage: one-entry hold register, RAW-hazard bubble insertion, flush squash, stall counter.
// Build option ID_DECODE_FWD_EN selects load-only hazard tracking (see id_hazard_scoreboard).
module id_decode_stage
  import id_decode_pkg::*;
#(
  parameter int unsigned NOFWD_DIST = 3,
  parameter int unsigned LOAD_DIST  = 2,
  parameter int unsigned CNT_W      = 16
) (
  input logic        clk,
  input logic        rst,
  id_decode_if.slave bus
);
  state_t        state_q, state_d;
  instr_fields_t hold, out_f;
  logic          hold_v, hazard, issue, accept, stall, out_valid;
  sb_entry_t     push;
  logic [CNT_W-1:0] stall_cnt;

  assign hold_v = (state_q != ST_EMPTY);

  id_hazard_scoreboard #(
    .NOFWD_DIST(NOFWD_DIST),
    .LOAD_DIST (LOAD_DIST)
  ) u_sb (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .rs    (hold.rs),
    .rt    (hold.rt),
    .use_rs(reads_rs(hold.op)),
    .use_rt(reads_rt(hold.op)),
    .hazard(hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (bus.instr_valid) state_d = ST_READY;
        ST_READY,
        ST_STALL: begin
          if (hazard)               state_d = ST_STALL;
          else if (bus.instr_valid) state_d = ST_READY;
          else                      state_d = ST_EMPTY;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    issue           = hold_v && !hazard && !bus.flush;
    stall           = hold_v && hazard && !bus.flush;
    bus.instr_ready = !bus.flush && (!hold_v || issue);
    accept          = bus.instr_valid && bus.instr_ready;
    push            = '0;
    if (issue) begin
      push.valid = writes_rd(hold.op) && (hold.rd != '0);
      push.rd    = hold.rd;
      push.is_ld = is_load(hold.op);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      out_f     <= '0;
      out_valid <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (accept) hold <= split(bus.instr);
      out_f     <= issue ? hold : '0;
      out_valid <= issue;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.OpCode    = out_f.op;
  assign bus.Rd        = out_f.rd;
  assign bus.Rs        = out_f.rs;
  assign bus.Rt        = out_f.rt;
  assign bus.Dir       = out_f.dir;
  assign bus.out_valid = out_valid;
  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed scenarios then random traffic against an issue-time model.
module tb_id_decode_stage;
  localparam int unsigned NOFWD = 3;
  localparam int unsigned LDD   = 2;
  localparam int unsigned CW    = 3;
`ifdef ID_DECODE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DIST = FWD ? int'(LDD) : int'(NOFWD);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_decode_if #(.CNT_W(CW)) bus ();

  id_decode_stage #(
    .NOFWD_DIST(NOFWD),
    .LOAD_DIST (LDD),
    .CNT_W     (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: edge index at which each register was last written (any writer / loads only).
  bit          m_hv;
  logic [31:0] m_hold;
  logic [31:0] m_out;
  bit          m_ov;
  bit          m_acc;
  int          m_t;
  int          last_wr [512];
  int          last_ld [512];
  logic [CW-1:0] m_cnt;

  function automatic logic [31:0] mk(int op, int rd, int rs, int rt);
    logic [31:0] w;
    w[31:27] = op[4:0];
    w[26:18] = rd[8:0];
    w[17:9]  = rs[8:0];
    w[8:0]   = rt[8:0];
    return w;
  endfunction

  function automatic bit src_blocked(int r);
    int w;
    if (r == 0) return 1'b0;
    w = FWD ? last_ld[r] : last_wr[r];
    return (m_t - w) < DIST;
  endfunction

  function automatic bit m_hazard();
    int op;
    op = int'(m_hold[31:27]);
    if (op == 0 || op == 3) return 1'b0;
    return src_blocked(int'(m_hold[17:9])) || src_blocked(int'(m_hold[8:0]));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 512; i++) begin
      last_wr[i] = -1000;
      last_ld[i] = -1000;
    end
    m_hv = 1'b0; m_hold = '0; m_out = '0; m_ov = 1'b0; m_cnt = '0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(bit r, bit v, logic [31:0] ins, bit f, string tag);
    bit hz, iss, rdy;
    int op, rd;
    @(negedge clk);
    rst = r; bus.instr_valid = v; bus.instr = ins; bus.flush = f;
    #1;
    hz  = m_hv && m_hazard();
    iss = m_hv && !hz && !f;
    rdy = !f && (!m_hv || iss);
    if (!r) chk({tag, ".ready"}, 32'(bus.instr_ready), 32'(rdy));
    m_acc = !r && v && rdy;
    if (r) begin
      m_clear();
    end else begin
      op = int'(m_hold[31:27]);
      rd = int'(m_hold[26:18]);
      if (iss && (op == 1 || op >= 5) && rd != 0) begin
        last_wr[rd] = m_t;
        if (op == 1) last_ld[rd] = m_t;
      end
      m_out = iss ? m_hold : '0;
      m_ov  = iss;
      if (hz && !f && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (f)          m_hv = 1'b0;
      else if (m_acc) m_hv = 1'b1;
      else if (iss)   m_hv = 1'b0;
      if (m_acc) m_hold = ins;
    end
    m_t++;
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_ov));
    chk({tag, ".OpCode"},    32'(bus.OpCode), 32'(m_out[31:27]));
    chk({tag, ".RdRsRt"},    32'({bus.Rd, bus.Rs, bus.Rt}), 32'(m_out[26:0]));
    chk({tag, ".Dir"},       32'(bus.Dir), 32'(m_out[26:0]));
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(m_cnt));
  endtask

  task automatic send(logic [31:0] ins, string tag);
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 1'b1, ins, 1'b0, tag);
      if (m_acc) return;
    end
    checks++;
    failures++;
    $display("FAIL %s.accept_timeout observed=not_accepted expected=accepted", tag);
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, tag);
  endtask

  initial begin
    int op, sel;
    m_t = 0;
    m_clear();
    rst = 1'b1; bus.instr_valid = 1'b0; bus.instr = '0; bus.flush = 1'b0;

    step(1'b1, 1'b0, '0, 1'b0, "reset0");
    step(1'b1, 1'b0, '0, 1'b0, "reset1");
    idle(1, "post_reset");

    send(mk(5, 1, 2, 3), "indep_a");
    send(mk(9, 6, 9, 8), "indep_b");
    idle(3, "indep_drain");

    send(mk(6, 5, 1, 2), "raw_w");
    send(mk(7, 4, 5, 3), "raw_r");
    idle(5, "raw_drain");

    send(mk(1, 7, 2, 0), "ld_w");
    send(mk(8, 3, 1, 7), "ld_use");
    idle(5, "ld_drain");

    send(mk(1, 7, 2, 0), "fl_ld");
    send(mk(5, 2, 7, 1), "fl_use");
    step(1'b0, 1'b0, '0, 1'b1, "flush");
    send(mk(10, 9, 4, 4), "fl_next");
    idle(5, "fl_drain");

    send(mk(5, 0, 1, 2), "rd0_w");
    send(mk(6, 3, 0, 0), "rd0_r");
    send(mk(3, 0, 3, 3), "jmp");
    idle(4, "rd0_drain");

    send(mk(1, 8, 1, 1), "rst_ld");
    send(mk(5, 2, 8, 8), "rst_use");
    step(1'b1, 1'b0, '0, 1'b0, "mid_rst");
    idle(2, "mid_rst_idle");

    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: op = 1;
        1: op = 2;
        2: op = 3;
        3: op = 4;
        default: op = int'($urandom_range(5, 31));
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           mk(op, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5))),
           $urandom_range(0, 15) == 0, "rand");
    end
    idle(4, "rand_drain");

    for (int i = 0; i < 10; i++) begin
      send(mk(1, 4, 0, 0), "sat_ld");
      send(mk(5, 1, 4, 4), "sat_use");
    end
    idle(4, "sat_drain");
    chk("sat.max", 32'(bus.stall_cnt), 32'((1 << CW) - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
